// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM encoding and rotated priority mask helper
package arb_pkg;

   localparam int ARB_MAX_REQ = 32;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Bits strictly above ptr are set; these requesters win ahead of a wrap.
   function automatic logic [ARB_MAX_REQ-1:0] rot_mask(input int ptr);
      logic [ARB_MAX_REQ-1:0] m;
      for (int i = 0; i < ARB_MAX_REQ; i++) begin
         m[i] = (i > ptr);
      end
      return m;
   endfunction

endpackage

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - one-hot to binary index encoder
module onehot_encoder #(
   parameter int INPUT_W  = 8,
   parameter int OUTPUT_W = 3
) (
   input  logic [INPUT_W-1:0]  onehot,
   output logic [OUTPUT_W-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < INPUT_W; i++) begin
         if (onehot[i]) begin
            bin = bin | OUTPUT_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first valid after ptr, ptr itself last
module rr_pick
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 8,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] v,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick
);

   logic [NUM_REQ-1:0]   mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] sel;
   logic                 found;

   // Low half holds only requesters above ptr, high half all of them, so the
   // lowest set bit of the doubled vector is the wrapped round-robin winner.
   always_comb begin
      mask  = NUM_REQ'(rot_mask(int'(ptr)));
      dbl   = {v, v & mask};
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < 2*NUM_REQ; i++) begin
         if (dbl[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      pick = sel[NUM_REQ-1:0] | sel[2*NUM_REQ-1:NUM_REQ];
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - registered round-robin arbiter; ARB_PACKET_LOCK_EN adds req_last packet locking
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 8,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef ARB_PACKET_LOCK_EN
   input  logic               req_last,
`endif
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   output logic               gnt_valid,
   input  logic               gnt_ready,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx
);

   arb_state_t         state, state_d;
   logic [IDX_W-1:0]   ptr, ptr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_ptr;
   logic               rearb;

   assign gnt_valid = (state == ARB_GRANT);
   assign req_ready = gnt_onehot & {NUM_REQ{gnt_valid & gnt_ready}};

`ifdef ARB_PACKET_LOCK_EN
   assign rearb = gnt_ready & req_last;
`else
   assign rearb = gnt_ready;
`endif

   // During a grant the next pick is relative to the index being retired.
   assign pick_ptr = gnt_valid ? gnt_idx : ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .v    (req_valid),
      .ptr  (pick_ptr),
      .pick (pick)
   );

   onehot_encoder #(
      .INPUT_W  (NUM_REQ),
      .OUTPUT_W (IDX_W)
   ) u_enc (
      .onehot (gnt_onehot),
      .bin    (gnt_idx)
   );

   always_comb begin
      state_d = state;
      gnt_d   = gnt_onehot;
      ptr_d   = ptr;
      case (state)
         ARB_IDLE: begin
            if (|req_valid) begin
               gnt_d   = pick;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (rearb) begin
               ptr_d = gnt_idx;
               if (|req_valid) begin
                  gnt_d = pick;
               end else begin
                  gnt_d   = '0;
                  state_d = ARB_IDLE;
               end
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         ptr        <= IDX_W'(NUM_REQ-1);
         gnt_onehot <= '0;
      end else begin
         state      <= state_d;
         ptr        <= ptr_d;
         gnt_onehot <= gnt_d;
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - table-driven bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_valid = '0;
   logic [7:0] req_ready;
   logic       gnt_valid;
   logic       gnt_ready = 1'b0;
   logic [7:0] gnt_onehot;
   logic [2:0] gnt_idx;
`ifdef ARB_PACKET_LOCK_EN
   logic       req_last = 1'b1;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         rst;
      logic [7:0] rv;
      logic       rdy;
      logic       ev;
      logic [7:0] eoh;
      logic [2:0] eidx;
      logic [7:0] err;
   } vec_t;

   vec_t tbl[$];

   rr_grant_arbiter #(
      .NUM_REQ (8),
      .IDX_W   (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ARB_PACKET_LOCK_EN
      .req_last   (req_last),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic check_all(input int row, input logic ev, input logic [7:0] eoh, input logic [2:0] eidx, input logic [7:0] err);
      check("gnt_valid", row, 32'(gnt_valid), 32'(ev));
      check("gnt_onehot", row, 32'(gnt_onehot), 32'(eoh));
      check("gnt_idx", row, 32'(gnt_idx), 32'(eidx));
      check("req_ready", row, 32'(req_ready), 32'(err));
   endtask

   task automatic add(input bit rst, input logic [7:0] rv, input logic rdy, input logic ev,
                      input logic [7:0] eoh, input logic [2:0] eidx, input logic [7:0] err);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rdy = rdy; v.ev = ev; v.eoh = eoh; v.eidx = eidx; v.err = err;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      gnt_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // single requester 2, handshake completes even though valid drops
      add(1, 8'h04, 1, 0, 8'h00, 0, 8'h00);
      add(0, 8'h00, 1, 1, 8'h04, 2, 8'h04);
      add(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
      // all valid: rotation 0..7,0 with no bubbles
      add(1, 8'hFF, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 9; i++) begin
         add(0, 8'hFF, 1, 1, 8'(1 << (i % 8)), 3'(i % 8), 8'(1 << (i % 8)));
      end
      // stall on grant 1 for 5 cycles while other requests toggle
      add(0, 8'hFF, 0, 1, 8'h02, 1, 8'h00);
      add(0, 8'h00, 0, 1, 8'h02, 1, 8'h00);
      add(0, 8'h55, 0, 1, 8'h02, 1, 8'h00);
      add(0, 8'hAA, 0, 1, 8'h02, 1, 8'h00);
      add(0, 8'h0F, 0, 1, 8'h02, 1, 8'h00);
      add(0, 8'h0C, 1, 1, 8'h02, 1, 8'h02);
      add(0, 8'h08, 1, 1, 8'h04, 2, 8'h04);
      add(0, 8'h00, 1, 1, 8'h08, 3, 8'h08);
      add(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
      // lone requester 5 re-granted every handshake, then wrap 6 -> 0
      add(1, 8'h20, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         add(0, 8'h20, 1, 1, 8'h20, 5, 8'h20);
      end
      add(0, 8'h41, 1, 1, 8'h20, 5, 8'h20);
      add(0, 8'h41, 1, 1, 8'h40, 6, 8'h40);
      add(0, 8'h00, 1, 1, 8'h01, 0, 8'h01);
      add(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);

      for (int k = 0; k < tbl.size(); k++) begin
         if (tbl[k].rst) do_reset();
         @(negedge clk);
         req_valid = tbl[k].rv;
         gnt_ready = tbl[k].rdy;
         #1;
         check_all(k, tbl[k].ev, tbl[k].eoh, tbl[k].eidx, tbl[k].err);
      end

      // asynchronous reset in the middle of a grant
      @(negedge clk);
      req_valid = 8'hFF;
      gnt_ready = 1'b0;
      @(negedge clk);
      #1;
      check("pre_reset_valid", 100, 32'(gnt_valid), 32'd1);
      #2;
      gnt_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      check_all(101, 0, 8'h00, 0, 8'h00);
      @(negedge clk);
      req_valid = 8'h81;
      rst_n     = 1'b1;
      #1;
      check_all(102, 0, 8'h00, 0, 8'h00);
      @(negedge clk);
      #1;
      check_all(103, 1, 8'h01, 0, 8'h01);
      @(negedge clk);
      #1;
      check_all(104, 1, 8'h80, 7, 8'h80);

`ifdef ARB_PACKET_LOCK_EN
      // three-beat packet from requester 0 stays locked until req_last
      do_reset();
      @(negedge clk);
      req_valid = 8'h03;
      gnt_ready = 1'b1;
      req_last  = 1'b0;
      @(negedge clk);
      #1;
      check_all(200, 1, 8'h01, 0, 8'h01);
      @(negedge clk);
      #1;
      check_all(201, 1, 8'h01, 0, 8'h01);
      @(negedge clk);
      req_last = 1'b1;
      #1;
      check_all(202, 1, 8'h01, 0, 8'h01);
      @(negedge clk);
      #1;
      check_all(203, 1, 8'h02, 1, 8'h02);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
